four_rr_arbiter: RTL

//  Four-way round-robin arbiter. It is the grant side of the 4-input OR request tree:
//  the OR tree reports that some source is requesting; this block decides which one.

---
 rtl/arb_pkg.sv | 19 +
 rtl/four_rr_arbiter_if.sv | 22 ++
 rtl/rr_pick4.sv | 39 +++
 rtl/four_rr_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and helpers for the four-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N    = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned CNTW = 8;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    // Index to one-hot grant vector.
    function automatic logic [N-1:0] onehot4(input logic [IDW-1:0] id);
        logic [N-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/four_rr_arbiter_if.sv
// Request/grant bundle between the four sources and the arbiter.
// hold_to exists only when ARB_HOLD_LIMIT_EN is defined.
interface four_rr_arbiter_if;
    import arb_pkg::*;

    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic           any_req;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
`ifdef ARB_HOLD_LIMIT_EN
    logic           hold_to;

    modport master (output req, done, input any_req, gnt, gnt_valid, gnt_id, hold_to);
    modport slave  (input req, done, output any_req, gnt, gnt_valid, gnt_id, hold_to);
`else
    modport master (output req, done, input any_req, gnt, gnt_valid, gnt_id);
    modport slave  (input req, done, output any_req, gnt, gnt_valid, gnt_id);
`endif

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set req bit scanning ptr, ptr+1, ... mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] pick,
    output logic           found
);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;

    // Rotate so that bit 0 of rot corresponds to req[ptr].
    always_comb begin
        rot = req;
        case (ptr)
            2'd0:    rot = req;
            2'd1:    rot = {req[0],   req[3:1]};
            2'd2:    rot = {req[1:0], req[3:2]};
            2'd3:    rot = {req[2:0], req[3]};
            default: rot = req;
        endcase
    end

    // Lowest set bit of the rotated vector wins; map back by adding ptr.
    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDW'(i);
            end
        end
    end

    assign pick  = IDW'(ptr + off);
    assign found = |req;

endmodule

// File: rtl/four_rr_arbiter.sv
// Four-way round-robin arbiter: grants one requester and holds the grant until
// the owner pulses done or drops req. Optional hold limit via ARB_HOLD_LIMIT_EN.
module four_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    four_rr_arbiter_if.slave  bus
);

    if ((HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_hold_max_chk
        $error("four_rr_arbiter: HOLD_MAX must be within 1..255");
    end

    logic           state_q,  state_d;
    logic [N-1:0]   gnt_q,    gnt_d;
    logic           gnt_vld_q, gnt_vld_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q,    ptr_d;

    logic [IDW-1:0] pick;
    logic           found;
    logic           owner_req;
    logic           owner_done;
    logic           limit_hit;
    logic           release_now;

`ifdef ARB_HOLD_LIMIT_EN
    logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;
    logic            hold_to_q,  hold_to_d;
`endif

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .pick  (pick),
        .found (found)
    );

    assign owner_req  = bus.req[gnt_id_q];
    assign owner_done = bus.done[gnt_id_q];

`ifdef ARB_HOLD_LIMIT_EN
    assign limit_hit = (hold_cnt_q == CNTW'(HOLD_MAX));
`else
    assign limit_hit = 1'b0;
`endif

    assign release_now = owner_done | ~owner_req | limit_hit;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_d = hold_cnt_q;
        hold_to_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d   = ST_GRANT;
                    gnt_d     = onehot4(pick);
                    gnt_vld_d = 1'b1;
                    gnt_id_d  = pick;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_d = CNTW'(1);
`endif
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    gnt_id_d  = '0;
                    ptr_d     = IDW'(gnt_id_q + IDW'(1));
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_d = '0;
                    // Only a release that would not otherwise have happened is forced.
                    hold_to_d  = limit_hit & ~owner_done & owner_req;
`endif
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (hold_cnt_q != {CNTW{1'b1}}) begin
                    hold_cnt_d = hold_cnt_q + CNTW'(1);
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
                gnt_id_d  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q <= '0;
            hold_to_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q <= hold_cnt_d;
            hold_to_q  <= hold_to_d;
`endif
        end
    end

    assign bus.any_req   = |bus.req;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_vld_q;
    assign bus.gnt_id    = gnt_id_q;
`ifdef ARB_HOLD_LIMIT_EN
    assign bus.hold_to   = hold_to_q;
`endif

endmodule
